// File: rtl/missile_pool.sv
// Pool of SHOT_AMOUNT missiles: slot allocation, per-frame motion, retirement, cooldown and draw request.
// Optional MISSILE_POOL_HIT_COUNT_EN adds a saturating count of edges with collision retirements.
module missile_pool #(
    parameter int                   SHOT_AMOUNT     = 7,
    parameter int                   RGB_WIDTH       = 8,
    parameter logic [RGB_WIDTH-1:0] MISSILE_COLOR   = 'h1F,
    parameter int                   MISSILE_W       = 2,
    parameter int                   MISSILE_H       = 5,
    parameter int                   SPEED           = 4,
    parameter bit                   DIRECTION       = 1'b0,
    parameter int                   X_OFFSET        = 15,
    parameter int                   Y_MIN           = 0,
    parameter int                   Y_MAX           = 479,
    parameter int                   COOLDOWN_FRAMES = 8,
    localparam int                  CNT_W           = $clog2(SHOT_AMOUNT + 1)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 shooting_pulse,
    input  logic                 startOfFrame,
    input  logic                 collision,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic [10:0]          shooter_X,
    input  logic [10:0]          shooter_Y,
    output logic                 missileDR,
    output logic [RGB_WIDTH-1:0] missileRGB,
`ifdef MISSILE_POOL_HIT_COUNT_EN
    output logic [15:0]          hit_count,
`endif
    output logic [CNT_W-1:0]     active_count,
    output logic                 shot_fired
);
    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic signed [11:0] SPD    = 12'(SPEED);
    localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);
    localparam logic signed [12:0] MW     = 13'(MISSILE_W);
    localparam logic signed [12:0] MH     = 13'(MISSILE_H);

    logic [SHOT_AMOUNT-1:0] act_q, act_d, dr_q, hit, free_oh, coll_ret;
    logic signed [11:0]     x_q [SHOT_AMOUNT];
    logic signed [11:0]     x_d [SHOT_AMOUNT];
    logic signed [11:0]     y_q [SHOT_AMOUNT];
    logic signed [11:0]     y_d [SHOT_AMOUNT];
    logic signed [11:0]     ny  [SHOT_AMOUNT];
    logic [CD_W-1:0]        cd_q, cd_d;
    logic                   shot_q, fire;
    logic signed [11:0]     spawn_x, spawn_y;
    logic signed [12:0]     px, py;

    // Lowest clear bit of act_q: the slot a fire request would claim.
    assign free_oh  = ~act_q & (act_q + SHOT_AMOUNT'(1));
    assign fire     = shooting_pulse && (cd_q == '0) && (|free_oh);
    assign coll_ret = {SHOT_AMOUNT{collision}} & act_q & dr_q;
    assign spawn_x  = {1'b0, shooter_X} + 12'(X_OFFSET);
    assign spawn_y  = {1'b0, shooter_Y};
    assign px       = {2'b00, pixelX};
    assign py       = {2'b00, pixelY};

    // Bounds are evaluated at 13 bits so X+W / Y+H cannot wrap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SHOT_AMOUNT; i++) begin
            hit[i] = act_q[i]
                  && ({x_q[i][11], x_q[i]} <= px) && (px < {x_q[i][11], x_q[i]} + MW)
                  && ({y_q[i][11], y_q[i]} <= py) && (py < {y_q[i][11], y_q[i]} + MH);
        end
    end

    always_comb begin
        act_d = act_q;
        x_d   = x_q;
        y_d   = y_q;
        for (int i = 0; i < SHOT_AMOUNT; i++) begin
            ny[i] = DIRECTION ? (y_q[i] + SPD) : (y_q[i] - SPD);
            if (act_q[i]) begin
                if (coll_ret[i]) begin
                    act_d[i] = 1'b0;
                end else if (startOfFrame) begin
                    if ((ny[i] < YMIN_S) || (ny[i] > YMAX_S)) act_d[i] = 1'b0;
                    else                                       y_d[i]   = ny[i];
                end
            end else if (fire && free_oh[i]) begin
                act_d[i] = 1'b1;
                x_d[i]   = spawn_x;
                y_d[i]   = spawn_y;
            end
        end
    end

    always_comb begin
        cd_d = cd_q;
        if (fire)                              cd_d = CD_W'(COOLDOWN_FRAMES);
        else if (startOfFrame && cd_q != '0)   cd_d = cd_q - CD_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            act_q  <= '0;
            dr_q   <= '0;
            cd_q   <= '0;
            shot_q <= 1'b0;
            for (int i = 0; i < SHOT_AMOUNT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q  <= act_d;
            dr_q   <= hit;
            cd_q   <= cd_d;
            shot_q <= fire;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

`ifdef MISSILE_POOL_HIT_COUNT_EN
    logic [15:0] hc_q, hc_d;
    always_comb begin
        hc_d = hc_q;
        if ((|coll_ret) && hc_q != 16'hFFFF) hc_d = hc_q + 16'd1;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) hc_q <= '0;
        else         hc_q <= hc_d;
    end
    assign hit_count = hc_q;
`endif

    always_comb begin
        active_count = '0;
        for (int i = 0; i < SHOT_AMOUNT; i++) active_count = active_count + CNT_W'(act_q[i]);
    end

    assign missileDR  = |dr_q;
    assign missileRGB = MISSILE_COLOR;
    assign shot_fired = shot_q;
endmodule

// File: tb/tb_missile_pool.sv
// Bench for missile_pool: directed table, hand-written corner sequences, random stimulus vs reference model.
module tb_missile_pool;
    localparam int N = 7;

    logic        clk = 1'b0, resetN = 1'b0;
    logic        sp = 1'b0, sof = 1'b0, coll = 1'b0;
    logic [10:0] px = '0, py = '0, sx = '0, sy = '0;
    wire         dr, shot;
    wire  [7:0]  rgb;
    wire  [2:0]  cnt;
`ifdef MISSILE_POOL_HIT_COUNT_EN
    wire  [15:0] hc;
`endif

    missile_pool dut (
        .clk(clk), .resetN(resetN), .shooting_pulse(sp), .startOfFrame(sof), .collision(coll),
        .pixelX(px), .pixelY(py), .shooter_X(sx), .shooter_Y(sy),
        .missileDR(dr), .missileRGB(rgb),
`ifdef MISSILE_POOL_HIT_COUNT_EN
        .hit_count(hc),
`endif
        .active_count(cnt), .shot_fired(shot)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: slot list with plain integer coordinates.
    bit m_act [N];
    int m_x [N], m_y [N];
    bit m_dr [N];
    int m_cd, m_hc;
    bit m_shot;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dr[i] = 0;
        end
        m_cd = 0; m_hc = 0; m_shot = 0;
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_act[i];
        return c;
    endfunction

    function automatic int m_any_dr();
        int a = 0;
        for (int i = 0; i < N; i++) a |= m_dr[i];
        return a;
    endfunction

    task automatic model_edge();
        int  sel = -1;
        bit  fire, anycoll = 0;
        bit  hitv [N];
        int  ny;
        for (int i = 0; i < N; i++) if (!m_act[i] && sel < 0) sel = i;
        fire = sp && m_cd == 0 && sel >= 0;
        for (int i = 0; i < N; i++)
            hitv[i] = m_act[i] && int'(px) >= m_x[i] && int'(px) < m_x[i] + 2
                               && int'(py) >= m_y[i] && int'(py) < m_y[i] + 5;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (coll && m_dr[i]) begin
                    m_act[i] = 0; anycoll = 1;
                end else if (sof) begin
                    ny = m_y[i] - 4;
                    if (ny < 0 || ny > 479) m_act[i] = 0;
                    else                    m_y[i] = ny;
                end
            end else if (fire && i == sel) begin
                m_act[i] = 1; m_x[i] = int'(sx) + 15; m_y[i] = int'(sy);
            end
        end
        if (fire)                 m_cd = 8;
        else if (sof && m_cd > 0) m_cd--;
        for (int i = 0; i < N; i++) m_dr[i] = hitv[i];
        m_shot = fire;
        if (anycoll && m_hc < 65535) m_hc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_missileDR", dr, m_any_dr());
        chk("model_active_count", cnt, m_cnt());
        chk("model_shot_fired", shot, m_shot);
`ifdef MISSILE_POOL_HIT_COUNT_EN
        chk("model_hit_count", hc, m_hc);
`endif
    endtask

    task automatic drive(input bit a_sp, input bit a_sof, input bit a_coll,
                         input int a_px, input int a_py, input int a_sx, input int a_sy);
        sp = a_sp; sof = a_sof; coll = a_coll;
        px = 11'(a_px); py = 11'(a_py); sx = 11'(a_sx); sy = 11'(a_sy);
        step();
        sp = 0; sof = 0; coll = 0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        resetN = 0; sp = 0; sof = 0; coll = 0; px = 0; py = 0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_missileDR", dr, 0);
        chk("reset_active_count", cnt, 0);
        chk("reset_shot_fired", shot, 0);
        model_reset();
        resetN = 1;
    endtask

    typedef struct {
        bit sp, sof, coll;
        int px, py, sx, sy;
        bit edr;
        int ecnt;
        bit eshot;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Launch at (100,400): X=115, Y=400; three frames bring it to Y=388, then probe the 2x5 box.
        tbl[0]  = '{1, 0, 0,   0,   0, 100, 400, 0, 1, 1};
        tbl[1]  = '{0, 0, 0,   0,   0,   0,   0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0,   0,   0,   0,   0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0,   0,   0,   0,   0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0,   0,   0,   0,   0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 115, 388,   0,   0, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 114, 388,   0,   0, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 116, 392,   0,   0, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 117, 388,   0,   0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 115, 393,   0,   0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 115, 387,   0,   0, 0, 1, 0};

        do_reset();
        chk("missileRGB", rgb, 8'h1F);
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].sp, tbl[k].sof, tbl[k].coll, tbl[k].px, tbl[k].py, tbl[k].sx, tbl[k].sy);
            chk($sformatf("tbl%0d_missileDR", k), dr, tbl[k].edr);
            chk($sformatf("tbl%0d_active_count", k), cnt, tbl[k].ecnt);
            chk($sformatf("tbl%0d_shot_fired", k), shot, tbl[k].eshot);
        end

        // Pool exhaustion: 7 launches, 8th dropped.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 0, 0, 20 + 60 * k, 400);
            chk($sformatf("pool_shot%0d", k), shot, (k < 7) ? 1 : 0);
            frames(9);
        end
        chk("pool_full_count", cnt, 7);

        // Cooldown: pulse 2 frames after a shot is dropped; after 8 frames accepted.
        do_reset();
        drive(1, 0, 0, 0, 0, 50, 300);
        frames(2);
        drive(1, 0, 0, 0, 0, 80, 300);
        chk("cooldown_drop", shot, 0);
        frames(6);
        drive(1, 0, 0, 0, 0, 80, 300);
        chk("cooldown_accept", shot, 1);
        chk("cooldown_count", cnt, 2);

        // Off-screen retire at Y=2 then slot reuse.
        do_reset();
        drive(1, 0, 0, 0, 0, 50, 2);
        chk("top_launch_count", cnt, 1);
        frames(1);
        chk("top_retire_count", cnt, 0);
        frames(7);
        drive(1, 0, 0, 0, 0, 50, 2);
        chk("top_reuse_shot", shot, 1);
        drive(0, 0, 0, 65, 2, 0, 0);
        chk("top_reuse_draw", dr, 1);

        // Two missiles, collision on slot1 only.
        do_reset();
        drive(1, 0, 0, 0, 0, 100, 300);
        frames(8);
        drive(1, 0, 0, 0, 0, 200, 300);
        drive(0, 0, 0, 215, 300, 0, 0);
        chk("coll_draw_slot1", dr, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("coll_count", cnt, 1);
`ifdef MISSILE_POOL_HIT_COUNT_EN
        chk("coll_hit_count", hc, 1);
`endif
        drive(0, 0, 0, 115, 268, 0, 0);
        chk("coll_slot0_alive", dr, 1);
        drive(0, 0, 0, 215, 300, 0, 0);
        chk("coll_slot1_gone", dr, 0);

        // Asynchronous reset mid-flight.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0, 100 * k, 400);
            if (k < 3) frames(8);
        end
        drive(0, 0, 0, 315, 400, 0, 0);
        chk("pre_reset_draw", dr, 1);
        chk("pre_reset_count", cnt, 4);
        #3 resetN = 0;
        #1;
        chk("async_reset_dr", dr, 0);
        chk("async_reset_count", cnt, 0);
        chk("async_reset_shot", shot, 0);
        do_reset();
        drive(1, 0, 0, 0, 0, 300, 100);
        chk("post_reset_shot", shot, 1);
        drive(0, 0, 0, 315, 100, 0, 0);
        chk("post_reset_draw", dr, 1);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int j, rx, ry;
            j = $urandom_range(0, N - 1);
            if (m_act[j] && $urandom_range(0, 1) == 1) begin
                rx = m_x[j] + $urandom_range(0, 3) - 1;
                ry = m_y[j] + $urandom_range(0, 6) - 1;
            end else begin
                rx = $urandom_range(0, 700);
                ry = $urandom_range(0, 500);
            end
            if (rx < 0) rx = 0;
            if (ry < 0) ry = 0;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  rx, ry, $urandom_range(0, 600), $urandom_range(0, 479));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
